// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned BLOCK_WORDS = 4;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned TAG_W       = 3;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned OFF_W       = 4;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned BADDR_W     = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

endpackage

// File: rtl/instr_cache_if.sv
// CPU fetch and instruction-memory block-read signals of the instruction cache.
interface instr_cache_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0]  address;
  logic [WORD_W-1:0]  INSTRUCTION;
  logic               IM_BUSYWAIT;
  logic               mem_read;
  logic [BADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0] mem_readInstruction;
  logic               mem_busywait;

  // Cache side.
  modport slave (
    input  address, mem_readInstruction, mem_busywait,
    output INSTRUCTION, IM_BUSYWAIT, mem_read, mem_address
  );

  // CPU / memory side.
  modport master (
    output address, mem_readInstruction, mem_busywait,
    input  INSTRUCTION, IM_BUSYWAIT, mem_read, mem_address
  );

endinterface

// File: rtl/icache_ctrl_fsm.sv
// Miss-handling controller: IDLE -> MEM_READ -> UPDATE, with stall and read-request decode.
module icache_ctrl_fsm
  import icache_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hit_i,
  input  logic mem_busywait_i,
  output logic mem_read_o,
  output logic busywait_o,
  output logic miss_start_o,
  output logic fill_we_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_read_o   = 1'b0;
    busywait_o   = 1'b0;
    miss_start_o = 1'b0;
    fill_we_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stall is combinational on the lookup, but held low while reset is asserted.
        busywait_o = rst_ni & ~hit_i;
        if (!hit_i) begin
          miss_start_o = 1'b1;
          state_d      = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read_o = 1'b1;
        busywait_o = 1'b1;
        if (!mem_busywait_i) begin
          fill_we_o = 1'b1;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        busywait_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/instr_cache.sv
// Read-only direct-mapped instruction cache (8 lines x 4 words) with block refill on miss.
// Optional hit/miss counters enabled by defining INSTR_CACHE_PERF_EN.
module instr_cache
  import icache_pkg::*;
(
  input logic          CLK,
  input logic          RESET,
  instr_cache_if.slave bus
`ifdef INSTR_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];
  logic [BADDR_W-1:0]   miss_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [1:0]       word;
  logic [IDX_W-1:0] fill_idx;
  logic             hit;
  logic             miss_start;
  logic             fill_we;
  logic             unused_byte_sel;

  assign tag             = bus.address[ADDR_W-1 -: TAG_W];
  assign idx             = bus.address[OFF_W +: IDX_W];
  assign word            = bus.address[3:2];
  assign unused_byte_sel = ^bus.address[1:0];
  assign fill_idx        = miss_q[IDX_W-1:0];

  assign hit             = valid_q[idx] && (tag_q[idx] == tag);
  assign bus.INSTRUCTION = data_q[idx][{word, 5'b00000} +: WORD_W];
  assign bus.mem_address = miss_q;

  icache_ctrl_fsm u_ctrl (
    .clk_i          (CLK),
    .rst_ni         (RESET),
    .hit_i          (hit),
    .mem_busywait_i (bus.mem_busywait),
    .mem_read_o     (bus.mem_read),
    .busywait_o     (bus.IM_BUSYWAIT),
    .miss_start_o   (miss_start),
    .fill_we_o      (fill_we)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      miss_q  <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (miss_start) miss_q <= {tag, idx};
      // Refill targets the latched block, independent of the current PC.
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
        tag_q[fill_idx]   <= miss_q[BADDR_W-1:IDX_W];
        data_q[fill_idx]  <= bus.mem_readInstruction;
      end
    end
  end

`ifdef INSTR_CACHE_PERF_EN
  logic [ADDR_W-1:0] addr_prev_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Outside reset, the stall is low only in IDLE with a hit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_prev_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      addr_prev_q <= bus.address;
      if (!bus.IM_BUSYWAIT && (bus.address != addr_prev_q) && (hit_cnt_q != 16'hFFFF))
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_start && (miss_cnt_q != 16'hFFFF))
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed fetches, a memory responder and a decoupled monitor.
module tb_instr_cache;
  import icache_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  instr_cache_if mif();

  instr_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (mif)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  function automatic logic [127:0] mk_block(input logic [5:0] b);
    logic [127:0] blk;
    logic [1:0]   kk;
    blk = '0;
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      blk[32*k +: 32] = 32'hC0DE_0000 | {22'd0, b, kk, 2'b00};
    end
    return blk;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: 5 busy cycles, then the block is valid.
  initial begin
    int cnt;
    cnt = 0;
    mif.mem_busywait        = 1'b1;
    mif.mem_readInstruction = '0;
    forever begin
      @(negedge CLK);
      if (mif.mem_read) begin
        cnt++;
        if (cnt > 5) begin
          mif.mem_busywait        = 1'b0;
          mif.mem_readInstruction = mk_block(mif.mem_address);
        end
      end else begin
        cnt = 0;
        mif.mem_busywait = 1'b1;
      end
    end
  end

  // Monitor: whenever the CPU may consume INSTRUCTION, check it against the next expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET && !mif.IM_BUSYWAIT && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr", mif.INSTRUCTION, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic access(input logic [9:0] a, input logic [31:0] e, input int exp_stall,
                        input logic [5:0] maddr, input bit rel);
    int n;
    @(negedge CLK);
    if (rel) RESET = 1'b1;
    mif.address = a;
    exp_q.push_back(e);
    #1;
    chk("busy_now", {31'd0, mif.IM_BUSYWAIT}, {31'd0, exp_stall != 0});
    n = 0;
    while (mif.IM_BUSYWAIT && n < 200) begin
      @(negedge CLK);
      n++;
      #1;
      if (n == 1) begin
        chk("mem_read", {31'd0, mif.mem_read}, 32'd1);
        chk("mem_addr", {26'd0, mif.mem_address}, {26'd0, maddr});
      end
    end
    if (exp_stall == 0) chk("mem_read_hit", {31'd0, mif.mem_read}, 32'd0);
    chk("stall", n, exp_stall);
  endtask

  initial begin
    int  n;
    bit  saw04;
    mif.address = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", {31'd0, mif.IM_BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'd0, mif.mem_read}, 32'd0);
    chk("rst_mem_addr", {26'd0, mif.mem_address}, 32'd0);
    chk("rst_instr", mif.INSTRUCTION, 32'd0);

    // Cold miss, then sequential hits (low address bits ignored)
    access(10'h000, 32'hC0DE_0000, 8, 6'h00, 1'b1);
    access(10'h004, 32'hC0DE_0004, 0, 6'h00, 1'b0);
    access(10'h008, 32'hC0DE_0008, 0, 6'h00, 1'b0);
    access(10'h00D, 32'hC0DE_000C, 0, 6'h00, 1'b0);

    // Conflict on index 0
    access(10'h080, 32'hC0DE_0080, 8, 6'h08, 1'b0);
    access(10'h084, 32'hC0DE_0084, 0, 6'h00, 1'b0);
    access(10'h000, 32'hC0DE_0000, 8, 6'h00, 1'b0);

    // Reset in the middle of a fill
    @(negedge CLK);
    mif.address = 10'h210;
    #1;
    chk("mid_busy", {31'd0, mif.IM_BUSYWAIT}, 32'd1);
    repeat (3) @(negedge CLK);
    #1;
    chk("mid_mem_read", {31'd0, mif.mem_read}, 32'd1);
    chk("mid_mem_addr", {26'd0, mif.mem_address}, 32'h21);
    RESET = 1'b0;
    #1;
    chk("abort_mem_read", {31'd0, mif.mem_read}, 32'd0);
    chk("abort_busy", {31'd0, mif.IM_BUSYWAIT}, 32'd0);
    chk("abort_instr", mif.INSTRUCTION, 32'd0);
    repeat (2) @(negedge CLK);
    access(10'h210, 32'hC0DE_0210, 8, 6'h21, 1'b1);
    access(10'h004, 32'hC0DE_0004, 8, 6'h00, 1'b0);

    // Address change mid-fill: block 0 completes, then 0x040 is fetched
    @(negedge CLK);
    RESET = 1'b0;
    mif.address = 10'h000;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    mif.address = 10'h040;
    exp_q.push_back(32'hC0DE_0040);
    #1;
    chk("chg_mem_read", {31'd0, mif.mem_read}, 32'd1);
    chk("chg_mem_addr", {26'd0, mif.mem_address}, 32'h00);
    n = 0;
    saw04 = 1'b0;
    while (mif.IM_BUSYWAIT && n < 200) begin
      @(negedge CLK);
      n++;
      #1;
      if (mif.mem_read && mif.mem_address == 6'h04) saw04 = 1'b1;
    end
    chk("chg_stall", n, 14);
    chk("chg_saw_blk04", {31'd0, saw04}, 32'd1);
    access(10'h000, 32'hC0DE_0000, 0, 6'h00, 1'b0);
    access(10'h04C, 32'hC0DE_004C, 0, 6'h00, 1'b0);

    repeat (3) @(negedge CLK);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
